// File: rtl/cpu_pkg.sv
// Shared CPU register-file constants and the register-file write bundle.
package cpu_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] R0 = '0;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rf_wr_t;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Bus between the pipeline/memory side (master) and the register-file write arbiter (slave).
interface rf_write_arbiter_if
    import cpu_pkg::*;
#(
    parameter int AW_P = cpu_pkg::AW,
    parameter int DW_P = cpu_pkg::DW
);
    logic            wb_valid;
    logic [AW_P-1:0] wb_addr;
    logic [DW_P-1:0] wb_data;
    logic            ld_issue;
    logic [AW_P-1:0] ld_issue_addr;
    logic            ld_valid;
    logic            ld_ready;
    logic [AW_P-1:0] ld_addr;
    logic [DW_P-1:0] ld_data;
    logic [AW_P-1:0] q_addr1, q_addr2, q_addrw;
    logic            pend1, pend2, pendw;
    logic            rf_we;
    logic [AW_P-1:0] rf_waddr;
    logic [DW_P-1:0] rf_wdata;

    modport master (
        output wb_valid, wb_addr, wb_data, ld_issue, ld_issue_addr,
               ld_valid, ld_addr, ld_data, q_addr1, q_addr2, q_addrw,
        input  ld_ready, pend1, pend2, pendw, rf_we, rf_waddr, rf_wdata
    );
    modport slave (
        input  wb_valid, wb_addr, wb_data, ld_issue, ld_issue_addr,
               ld_valid, ld_addr, ld_data, q_addr1, q_addr2, q_addrw,
        output ld_ready, pend1, pend2, pendw, rf_we, rf_waddr, rf_wdata
    );
endinterface

// File: rtl/rf_wr_fifo.sv
// Synchronous FIFO for load returns; head entry is presented combinationally on dout.
module rf_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr, rptr;

    assign dout  = mem[rptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= din;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Merges pipeline writeback (strict priority) with buffered load returns onto the
// register-file write port, and tracks registers still owed by outstanding loads.
module rf_write_arbiter
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = cpu_pkg::DW,
    parameter int AW    = cpu_pkg::AW
) (
    input  logic clock,
    input  logic reset,
    rf_write_arbiter_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int NR = 1 << AW;

    logic [AW+DW-1:0] head;
    logic             full, empty;
    logic [CW-1:0]    count;
    logic             wb_hit, push, pop;
    logic [AW-1:0]    head_addr;
    logic [DW-1:0]    head_data;
    logic [NR-1:0]    mask, mask_nxt;
    rf_wr_t           rf_q;

    assign {head_addr, head_data} = head;

    // Writes to r0 are treated as idle; discarded r0 load returns still take ld_ready.
    assign wb_hit       = bus.wb_valid && (bus.wb_addr != R0);
    assign pop          = !wb_hit && !empty;
    assign bus.ld_ready = !full;
    assign push         = bus.ld_valid && !full && (bus.ld_addr != R0);

    rf_wr_fifo #(.DEPTH(DEPTH), .W(AW + DW), .CW(CW)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   ({bus.ld_addr, bus.ld_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rf_q <= '0;
        end else if (wb_hit) begin
            rf_q <= '{we: 1'b1, addr: bus.wb_addr, data: bus.wb_data};
        end else if (pop) begin
            rf_q <= '{we: 1'b1, addr: head_addr, data: head_data};
        end else begin
            rf_q.we <= 1'b0;
        end
    end

    assign bus.rf_we    = rf_q.we;
    assign bus.rf_waddr = rf_q.addr;
    assign bus.rf_wdata = rf_q.data;

    // Clear first, then set, so a re-issue to the same register in the pop cycle wins.
    always_comb begin
        mask_nxt = mask;
        if (pop) mask_nxt[head_addr] = 1'b0;
        if (bus.ld_issue && (bus.ld_issue_addr != R0)) mask_nxt[bus.ld_issue_addr] = 1'b1;
        mask_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) mask <= '0;
        else       mask <= mask_nxt;
    end

    assign bus.pend1 = mask[bus.q_addr1];
    assign bus.pend2 = mask[bus.q_addr2];
    assign bus.pendw = mask[bus.q_addrw];
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-side front end of the CPU register file. Merges the non-stallable pipeline writeback stream with late load returns from the cache/DDR path into the register file's single write port (write_enable/waddr/wdata). Load returns are buffered in a small FIFO. A 32-bit pending-load scoreboard lets decode stall on operands or destinations still owed by an outstanding load.

## Interface
Parameters:
- DEPTH, 4, load-return FIFO entries; power of two, ≥2
- DW, 32, data width
- AW, 5, register address width

Ports:
- clock  in  1  rising-edge clock for all state
- reset  in  1  reset, asynchronous, active-high
- wb_valid  in  1  pipeline writeback valid; never backpressured
- wb_addr  in  AW  writeback destination
- wb_data  in  DW  writeback data
- ld_issue  in  1  load issued to memory stage this cycle
- ld_issue_addr  in  AW  destination of issued load
- ld_valid  in  1  load return valid
- ld_ready  out  1  FIFO can accept a load return
- ld_addr  in  AW  load return destination
- ld_data  in  DW  load return data
- q_addr1, q_addr2, q_addrw  in  AW  decode query addresses (rs, rt, dest)
- pend1, pend2, pendw  out  1  query hits a pending-load register (combinational)
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data

## Operation
- Load FIFO: push on ld_valid && ld_ready. A return with ld_addr==0 is accepted (ld_ready honoured) and discarded, not pushed.
- ld_ready = (count != DEPTH), driven from registered count only; no same-cycle pop credit.
- Arbitration each rising edge, pipeline writeback has strict priority:
  - wb_valid && wb_addr!=0: drive the wb entry; FIFO holds.
  - else FIFO non-empty: pop head and drive it.
  - else rf_we=0.
- A wb with wb_addr==0 counts as idle; the FIFO may drain that cycle.
- Scoreboard mask[31:0]:
  - ld_issue with ld_issue_addr!=0 sets the bit.
  - A popped FIFO entry driven to rf_* clears its bit.
  - Set and clear of the same bit in the same cycle: set wins.
  - Bit 0 is always 0.
- pendN = mask[q_addrN]. Queries for address 0 return 0.
- Decode stalls on pendw, so at most one load is outstanding per register and no WAW ordering between wb and load sources is needed.

## Timing
- rf_we/rf_waddr/rf_wdata are registered and held stable for a full cycle. The register file samples them on the falling edge inside that cycle.
- Writeback latency: sampled at edge N, driven N..N+1.
- Load latency: pushed at edge N, earliest driven N+1..N+2 (2 edges minimum). It is delayed one extra cycle per consecutive non-zero wb.
- Scoreboard bit clears at the edge that drives the load write. pend drops in that same cycle; the data is visible via the register file's combinational read after the falling edge.
- Simultaneous push and pop: legal when not full; count unchanged.
- Full FIFO: ld_ready=0 and pop proceeds normally.
- Pointer wrap: modulo DEPTH. Count width is clog2(DEPTH+1).
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, ld_ready=1, mask=0, count=0, pointers=0, pend*=0.
- Reset mid-operation: queued loads and pending bits are discarded. Issuers must also be reset.

## Structure
- Shared package (cpu_pkg): AW, DW, R0 constant, and the rf write-bundle typedef {we, addr, data}.
- Sub-module rf_wr_fifo: synchronous FIFO (DEPTH × (AW+DW)) with push/pop, count, full/empty, and async active-high reset.
- Arbiter, scoreboard and output register live in rf_write_arbiter.

## Test plan
- wb_valid with addr=5, data=0x1234 at edge 1 -> rf_we=1, rf_waddr=5, rf_wdata=0x1234 during cycle 1–2; FIFO untouched.
- ld_issue addr=8; later ld_valid addr=8, data=0xCAFE with wb idle -> pend(q=8)=1 until the write cycle; rf_we drives 8/0xCAFE 2 edges after the return; pend then 0.
- Push 4 loads (regs 9–12) while wb_valid every cycle -> ld_ready=0 after the 4th push. Drop wb -> FIFO drains in order 9, 10, 11, 12 on consecutive cycles; ld_ready returns to 1 after the first pop.
- ld_valid addr=0 and wb addr=0 -> no rf_we; count stays 0; mask[0] stays 0.
- Same-cycle ld_issue addr=3 and pop of an older load to reg 3 -> write is driven and mask[3] remains 1.
- Assert reset with 3 entries queued and mask≠0 -> all outputs at reset values immediately (async); no stale writes after release.
